// File: rtl/nco_pkg.sv
// Shared types, default widths and helpers for the NCO phase generator.
// Optional quadrature output is enabled with the NCO_QUAD_EN macro.
package nco_pkg;

    localparam int unsigned ACC_LENGTH_DEF  = 32;
    localparam int unsigned ADDR_LENGTH_DEF = 8;
    localparam int unsigned CNT_LENGTH_DEF  = 16;
    localparam logic [31:0] FCW_INIT_DEF    = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } nco_state_e;

    // Address increment corresponding to +90 degrees of phase.
    function automatic int unsigned QUARTER_OFFSET(input int unsigned addr_length);
        return 32'd1 << (addr_length - 32'd2);
    endfunction

endpackage

// File: rtl/nco_fcw_shadow.sv
// FCW shadow register: valid/ready capture and phase-continuous apply.
module nco_fcw_shadow
    import nco_pkg::*;
#(
    parameter int unsigned           ACC_LENGTH = ACC_LENGTH_DEF,
    parameter logic [ACC_LENGTH-1:0] FCW_INIT   = ACC_LENGTH'(FCW_INIT_DEF)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ACC_LENGTH-1:0] fcw_i,
    input  logic                  fcw_valid_i,
    input  logic                  apply_trig_i,
    output logic                  fcw_ready_o,
    output logic [ACC_LENGTH-1:0] fcw_active_o
);

    logic                  empty_q,  empty_d;
    logic [ACC_LENGTH-1:0] shadow_q, shadow_d;
    logic [ACC_LENGTH-1:0] active_q, active_d;

    // Capture on handshake; move shadow to active on the first apply trigger.
    always_comb begin
        empty_d  = empty_q;
        shadow_d = shadow_q;
        active_d = active_q;
        if (fcw_valid_i && empty_q) begin
            shadow_d = fcw_i;
            empty_d  = 1'b0;
        end else if (!empty_q && apply_trig_i) begin
            active_d = shadow_q;
            empty_d  = 1'b1;
        end
    end

    // Shadow and active FCW registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            empty_q  <= 1'b1;
            shadow_q <= '0;
            active_q <= FCW_INIT;
        end else begin
            empty_q  <= empty_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign fcw_ready_o  = empty_q;
    assign fcw_active_o = active_q;

endmodule

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO producing lookup ROM addresses and a wrap timebase.
// Define NCO_QUAD_EN to add a +90 degree address output (address_q_out).
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int unsigned           ACC_LENGTH  = ACC_LENGTH_DEF,
    parameter int unsigned           ADDR_LENGTH = ADDR_LENGTH_DEF,
    parameter logic [ACC_LENGTH-1:0] FCW_INIT    = ACC_LENGTH'(FCW_INIT_DEF),
    parameter int unsigned           CNT_LENGTH  = CNT_LENGTH_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ena_in,
    input  logic                   sync_in,
    input  logic [ACC_LENGTH-1:0]  fcw_in,
    input  logic                   fcw_valid_in,
    output logic                   fcw_ready_out,
    input  logic [ADDR_LENGTH-1:0] phase_in,
    output logic [ADDR_LENGTH-1:0] address_out,
    output logic                   ena_out,
    output logic                   wrap_out,
    output logic [CNT_LENGTH-1:0]  wrap_count_out
`ifdef NCO_QUAD_EN
    ,
    output logic [ADDR_LENGTH-1:0] address_q_out
`endif
);

`ifdef NCO_QUAD_EN
    localparam logic [ADDR_LENGTH-1:0] QUAD_OFS = ADDR_LENGTH'(QUARTER_OFFSET(ADDR_LENGTH));
    logic [ADDR_LENGTH-1:0] addr_q_q, addr_q_d;
`endif

    nco_state_e             state_q, state_d;
    logic [ACC_LENGTH-1:0]  acc_q,   acc_d;
    logic [ADDR_LENGTH-1:0] addr_q,  addr_d;
    logic                   ena_q,   ena_d;
    logic                   wrap_q,  wrap_d;
    logic [CNT_LENGTH-1:0]  cnt_q,   cnt_d;

    logic [ACC_LENGTH-1:0]  fcw_active;
    logic                   fcw_ready;
    logic [ACC_LENGTH:0]    sum_c;
    logic                   wrap_c;
    logic                   apply_trig_c;
    logic                   apply_c;
    logic                   hs_c;

    // Carry out of the accumulator add is the wrap; sync suppresses it.
    assign sum_c        = {1'b0, acc_q} + {1'b0, fcw_active};
    assign wrap_c       = sum_c[ACC_LENGTH] & ena_in & ~sync_in;
    assign apply_trig_c = wrap_c | ~ena_in | sync_in;
    assign apply_c      = ~fcw_ready & apply_trig_c;
    assign hs_c         = fcw_valid_in & fcw_ready;

    nco_fcw_shadow #(
        .ACC_LENGTH (ACC_LENGTH),
        .FCW_INIT   (FCW_INIT)
    ) u_shadow (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .fcw_i        (fcw_in),
        .fcw_valid_i  (fcw_valid_in),
        .apply_trig_i (apply_trig_c),
        .fcw_ready_o  (fcw_ready),
        .fcw_active_o (fcw_active)
    );

    // Next-state: FSM, accumulator, address and wrap counter.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        ena_d   = ena_in;
        wrap_d  = wrap_c;
        cnt_d   = cnt_q;
`ifdef NCO_QUAD_EN
        addr_q_d = addr_q_q;
`endif

        case (state_q)
            IDLE:    if (ena_in) state_d = (hs_c || (!fcw_ready && !apply_c)) ? PEND : RUN;
            RUN:     if (hs_c) state_d = PEND;
            PEND:    if (apply_c) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!ena_in) state_d = IDLE;

        if (sync_in) begin
            acc_d = '0;
        end else if (ena_in) begin
            acc_d = sum_c[ACC_LENGTH-1:0];
        end

        if (ena_in) begin
            addr_d = sync_in ? phase_in : (acc_q[ACC_LENGTH-1 -: ADDR_LENGTH] + phase_in);
        end

        if (wrap_c) cnt_d = cnt_q + CNT_LENGTH'(1);

`ifdef NCO_QUAD_EN
        if (ena_in) addr_q_d = addr_d + QUAD_OFS;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            addr_q  <= '0;
            ena_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef NCO_QUAD_EN
            addr_q_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            ena_q   <= ena_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
`ifdef NCO_QUAD_EN
            addr_q_q <= addr_q_d;
`endif
        end
    end

    assign fcw_ready_out  = fcw_ready;
    assign address_out    = addr_q;
    assign ena_out        = ena_q;
    assign wrap_out       = wrap_q;
    assign wrap_count_out = cnt_q;
`ifdef NCO_QUAD_EN
    assign address_q_out  = addr_q_q;
`endif

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen (honours NCO_QUAD_EN).
module tb_nco_phase_gen;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        ena_in = 1'b0;
    logic        sync_in = 1'b0;
    logic [31:0] fcw_in = '0;
    logic        fcw_valid_in = 1'b0;
    logic        fcw_ready_out;
    logic [7:0]  phase_in = '0;
    logic [7:0]  address_out;
    logic        ena_out;
    logic        wrap_out;
    logic [15:0] wrap_count_out;
`ifdef NCO_QUAD_EN
    logic [7:0]  address_q_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    nco_phase_gen dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .ena_in         (ena_in),
        .sync_in        (sync_in),
        .fcw_in         (fcw_in),
        .fcw_valid_in   (fcw_valid_in),
        .fcw_ready_out  (fcw_ready_out),
        .phase_in       (phase_in),
        .address_out    (address_out),
        .ena_out        (ena_out),
        .wrap_out       (wrap_out),
        .wrap_count_out (wrap_count_out)
`ifdef NCO_QUAD_EN
        ,
        .address_q_out  (address_q_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address check; quadrature output must track +0x40.
    task automatic chk_addr(input string tag, input logic [7:0] exp);
        chk(tag, 32'(address_out), 32'(exp));
`ifdef NCO_QUAD_EN
        chk({tag, "_quad"}, 32'(address_q_out), 32'(8'(exp + 8'h40)));
`endif
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Reset values
        #1 rst_in = 1'b1;
        #3;
        chk("rst_addr", 32'(address_out), 32'h0);
        chk("rst_ena", 32'(ena_out), 32'h0);
        chk("rst_wrap", 32'(wrap_out), 32'h0);
        chk("rst_cnt", 32'(wrap_count_out), 32'h0);
        chk("rst_ready", 32'(fcw_ready_out), 32'h1);
`ifdef NCO_QUAD_EN
        chk("rst_quad", 32'(address_q_out), 32'h0);
`endif
        step();
        rst_in = 1'b0;
        ena_in = 1'b1;

        // FCW_INIT step 1: 0..255 with one wrap at 0xFF
        for (int i = 0; i < 256; i++) begin
            step();
            chk_addr("ramp_addr", 8'(i));
            chk("ramp_wrap", 32'(wrap_out), (i == 255) ? 32'h1 : 32'h0);
            chk("ramp_ena", 32'(ena_out), 32'h1);
        end
        chk("ramp_cnt", 32'(wrap_count_out), 32'h1);
        step();
        chk_addr("ramp_post", 8'h00);
        chk("ramp_post_wrap", 32'(wrap_out), 32'h0);

        // Phase offset 0x40 after a sync: 0x40,0x40,0x41,..,0xFF,0x00
        sync_in  = 1'b1;
        phase_in = 8'h40;
        step();
        chk_addr("ph_sync", 8'h40);
        chk("ph_sync_wrap", 32'(wrap_out), 32'h0);
        sync_in = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step();
            chk_addr("ph_addr", 8'(32'h3F + k));
            chk("ph_wrap", 32'(wrap_out), 32'h0);
        end
        chk("ph_cnt", 32'(wrap_count_out), 32'h1);

        // FCW change mid-period, applied at the wrap
        phase_in = 8'h00;
        sync_in  = 1'b1;
        step();
        chk_addr("fcw_sync", 8'h00);
        sync_in = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            fcw_valid_in = (k == 101) || (k >= 110 && k <= 200);
            fcw_in       = (k == 101) ? 32'h0200_0000 : 32'h0300_0000;
            step();
            chk_addr("fcw_addr", 8'(k - 1));
            chk("fcw_wrap", 32'(wrap_out), 32'h0);
            chk("fcw_ready", 32'(fcw_ready_out), (k >= 101) ? 32'h0 : 32'h1);
        end
        fcw_valid_in = 1'b0;
        step();
        chk_addr("fcw_wrap_addr", 8'hFF);
        chk("fcw_wrap_pulse", 32'(wrap_out), 32'h1);
        chk("fcw_wrap_cnt", 32'(wrap_count_out), 32'h2);
        chk("fcw_ready_back", 32'(fcw_ready_out), 32'h1);
        for (int j = 1; j <= 10; j++) begin
            step();
            chk_addr("fcw_step2", 8'(2 * (j - 1)));
            chk("fcw_step2_wrap", 32'(wrap_out), 32'h0);
        end

        // ena_in low for 10 cycles: everything holds
        ena_in = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            chk_addr("hold_addr", 8'h12);
            chk("hold_ena", 32'(ena_out), 32'h0);
            chk("hold_cnt", 32'(wrap_count_out), 32'h2);
            chk("hold_wrap", 32'(wrap_out), 32'h0);
        end
        ena_in = 1'b1;
        step();
        chk_addr("resume0", 8'h14);
        chk("resume_ena", 32'(ena_out), 32'h1);
        step();
        chk_addr("resume1", 8'h16);

        // Sync at 0x80 with a pending FCW of step 1
        for (int m = 0; m <= 52; m++) begin
            fcw_valid_in = (m == 0);
            fcw_in       = 32'h0100_0000;
            step();
            chk_addr("pre_sync", 8'(24 + 2 * m));
        end
        fcw_valid_in = 1'b0;
        chk("pend_ready", 32'(fcw_ready_out), 32'h0);
        sync_in  = 1'b1;
        phase_in = 8'h10;
        step();
        chk_addr("sync_addr", 8'h10);
        chk("sync_wrap", 32'(wrap_out), 32'h0);
        chk("sync_cnt", 32'(wrap_count_out), 32'h2);
        chk("sync_ready", 32'(fcw_ready_out), 32'h1);
        sync_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_addr("post_sync", 8'(8'h10 + j));
        end

        // Asynchronous reset while an FCW is pending
        fcw_valid_in = 1'b1;
        fcw_in       = 32'h0400_0000;
        step();
        fcw_valid_in = 1'b0;
        chk("ar_pend_ready", 32'(fcw_ready_out), 32'h0);
        #1 rst_in = 1'b1;
        #1;
        chk("ar_addr", 32'(address_out), 32'h0);
        chk("ar_ena", 32'(ena_out), 32'h0);
        chk("ar_wrap", 32'(wrap_out), 32'h0);
        chk("ar_cnt", 32'(wrap_count_out), 32'h0);
        chk("ar_ready", 32'(fcw_ready_out), 32'h1);
`ifdef NCO_QUAD_EN
        chk("ar_quad", 32'(address_q_out), 32'h0);
`endif
        #1 rst_in = 1'b0;
        phase_in = 8'h00;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_addr("ar_init_fcw", 8'(j));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
